// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access sequencer.
// One request per instruction through an IDLE -> REQ -> DONE handshake,
// stalling the pipeline until the memory acknowledges.
// Optional feature: define MEM_TIMEOUT_EN to abort a request that has not been
// acknowledged within TIMEOUT_CYCLES REQ cycles (err pulse in DONE).
module mem_access_unit #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_en,
  input  logic              rw,
  input  logic              data_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              wb_en,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state;
  logic   cap_rw;
  logic   cap_dw;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tcnt;
  logic             at_limit;

  // This REQ cycle is the last one allowed without an acknowledge.
  always_comb begin
    at_limit = (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end
`else
  assign err = 1'b0;
`endif

  // Hold the pipeline while an instruction is being accepted or is waiting on memory.
  always_comb begin
    stall = (state == REQ) || ((state == IDLE) && mem_en);
  end

  // Request sequencer; all memory-side and write-back outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cap_rw      <= 1'b0;
      cap_dw      <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      wb_en       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      err         <= 1'b0;
      tcnt        <= '0;
`endif
    end else begin
      rdata_valid <= 1'b0;
      wb_en       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      err         <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (mem_en) begin
            mem_addr  <= addr;
            mem_wdata <= wdata;
            mem_we    <= ~rw;
            cap_rw    <= rw;
            cap_dw    <= data_write;
            mem_req   <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            tcnt      <= '0;
`endif
            state     <= REQ;
          end
        end
        REQ: begin
          // An acknowledge on the limit cycle still completes normally.
          if (mem_ack) begin
            mem_req     <= 1'b0;
            rdata_valid <= cap_rw;
            wb_en       <= cap_dw;
            if (cap_rw) begin
              rdata <= mem_rdata;
            end
            state <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (at_limit) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        DONE: begin
          // mem_en here belongs to the instruction being completed.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver issues instructions and pushes
// the expected memory request and the expected completion into queues; a
// monitor pops and compares whenever the DUT starts a request or completes one.
module tb_mem_access_unit;

  localparam int T = 4;

  logic        clk;
  logic        rst_n;
  logic        mem_en;
  logic        rw;
  logic        data_write;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        stall;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        wb_en;
  logic        err;

  mem_access_unit #(
    .ADDR_W(16),
    .DATA_W(16),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_en(mem_en),
    .rw(rw),
    .data_write(data_write),
    .addr(addr),
    .wdata(wdata),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .stall(stall),
    .rdata(rdata),
    .rdata_valid(rdata_valid),
    .wb_en(wb_en),
    .err(err)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  typedef struct packed {
    logic        rv;
    logic        wb;
    logic        er;
    logic [15:0] rd;
  } done_t;

  req_t        req_q[$];
  done_t       done_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] last_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares requests and completions against the scoreboard queues.
  logic        prev_req = 1'b0;
  logic [15:0] hold_rd  = '0;
  req_t        cur_req  = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
      hold_rd  = '0;
    end else begin
      if (mem_req && !prev_req) begin
        if (req_q.size() == 0) begin
          check("unexpected_request", 64'(mem_req), 64'(0));
        end else begin
          cur_req = req_q.pop_front();
          check("request", {mem_we, mem_addr, mem_wdata}, cur_req);
        end
      end else if (mem_req && prev_req) begin
        check("request_stable", {mem_we, mem_addr, mem_wdata}, cur_req);
      end
      if (prev_req && !mem_req) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 64'(1), 64'(0));
        end else begin
          done_t d;
          d = done_q.pop_front();
          check("done", {rdata_valid, wb_en, err, rdata}, d);
          hold_rd = d.rd;
        end
      end else begin
        check("outside_done", {rdata_valid, wb_en, err, rdata}, {3'b000, hold_rd});
      end
      prev_req = mem_req;
    end
  end

  // One instruction; entered and left at 1 time unit after a rising edge.
  // lat = REQ cycles before the one carrying mem_ack.
  task automatic txn(input logic r, input logic dw, input logic [15:0] a,
                     input logic [15:0] wd, input int unsigned lat,
                     input logic [15:0] rd, input logic hold);
    int unsigned nreq;
    logic        timeout;
    int          stall_cnt;
    done_t       d;
`ifdef MEM_TIMEOUT_EN
    timeout = (lat >= T);
    nreq    = timeout ? T : lat + 1;
`else
    timeout = 1'b0;
    nreq    = lat + 1;
`endif
    mem_en     = 1'b1;
    rw         = r;
    data_write = dw;
    addr       = a;
    wdata      = wd;
    req_q.push_back('{we: ~r, addr: a, wdata: wd});
    d.er = timeout;
    d.rv = timeout ? 1'b0 : r;
    d.wb = timeout ? 1'b0 : dw;
    d.rd = (!timeout && r) ? rd : last_rd;
    last_rd = d.rd;
    done_q.push_back(d);
    stall_cnt = 0;
    @(negedge clk);
    if (stall) stall_cnt++;
    for (int unsigned i = 0; i < nreq; i++) begin
      @(posedge clk); #1;
      if (!hold) mem_en = 1'b0;
      rw        = 1'($urandom);
      addr      = 16'($urandom);
      wdata     = 16'($urandom);
      mem_ack   = (i == lat);
      mem_rdata = (i == lat) ? rd : 16'($urandom);
      @(negedge clk);
      if (stall) stall_cnt++;
    end
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = 16'($urandom);
    @(negedge clk);
    check("done_stall", 64'(stall), 64'(0));
    check("stall_cycles", 64'(stall_cnt), 64'(nreq + 1));
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    mem_en     = 1'b0;
    rw         = 1'b0;
    data_write = 1'b0;
    addr       = '0;
    wdata      = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    last_rd    = '0;
    #2;
    check("reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, rdata, rdata_valid, wb_en, err, stall}, 64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Load with ack in the second REQ cycle, then a single-cycle store.
    txn(1'b1, 1'b1, 16'h0040, 16'h0000, 1, 16'hBEEF, 1'b0);
    txn(1'b0, 1'b0, 16'h0010, 16'h1234, 0, 16'h5555, 1'b0);

    // Back-to-back with mem_en held high through DONE.
    txn(1'b1, 1'b1, 16'h0100, 16'h0001, 0, 16'hA5A5, 1'b1);
    txn(1'b0, 1'b1, 16'h0102, 16'h0002, 2, 16'h0BAD, 1'b1);
    txn(1'b1, 1'b0, 16'h0104, 16'h0003, 0, 16'h7E57, 1'b0);

    // No ack past the limit, then ack exactly on the limit cycle.
    txn(1'b1, 1'b1, 16'h0200, 16'h0000, T + 2, 16'hC0DE, 1'b0);
    txn(1'b1, 1'b1, 16'h0202, 16'h0000, T - 1, 16'hFACE, 1'b0);

    // Stray acknowledges while idle.
    for (int k = 0; k < 3; k++) begin
      mem_ack   = 1'b1;
      mem_rdata = 16'($urandom);
      @(negedge clk);
      check("stray_ack_idle", {stall, mem_req, rdata}, {2'b00, last_rd});
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;

    // Randomized instructions.
    for (int k = 0; k < 40; k++) begin
      txn(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
          $urandom_range(0, 6), 16'($urandom), 1'($urandom));
    end
    txn(1'b1, 1'b1, 16'h0300, 16'h0000, 0, 16'h1357, 1'b0);

    // Reset one cycle into REQ; a late ack must not complete anything.
    mem_en     = 1'b1;
    rw         = 1'b1;
    data_write = 1'b1;
    addr       = 16'h0400;
    wdata      = 16'h0000;
    req_q.push_back('{we: 1'b0, addr: 16'h0400, wdata: 16'h0000});
    @(posedge clk); #1;
    mem_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("reset_mid_req", {mem_req, rdata, rdata_valid, wb_en}, 64'(0));
    last_rd = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    @(negedge clk);
    check("late_ack_ignored", {stall, mem_req}, 64'(0));
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;

    // Recovery after reset.
    txn(1'b1, 1'b1, 16'h0500, 16'h0000, 1, 16'h2468, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("req_queue_drained", 64'(req_q.size()), 64'(0));
    check("done_queue_drained", 64'(done_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: width of the data-memory address.
REQ-002 SHALL have parameter DATA_W, default 16: width of the data word.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 15: number of REQ cycles without acknowledge before an abort (used only with MEM_TIMEOUT_EN).
REQ-004 Port list, clock and reset first:
 clk  in  1  single clock, all state on rising edge
 rst_n  in  1  asynchronous, active-low reset
 mem_en  in  1  memory operation requested by the decoded instruction in the MEM stage
 rw  in  1  1 = read (load), 0 = write (store)
 data_write  in  1  instruction writes the register file
 addr  in  ADDR_W  effective address
 wdata  in  DATA_W  store data
 mem_req  out  1  request to data memory
 mem_we  out  1  1 = memory write
 mem_addr  out  ADDR_W  registered address to memory
 mem_wdata  out  DATA_W  registered store data to memory
 mem_ack  in  1  memory completed the current request
 mem_rdata  in  DATA_W  read data, valid with mem_ack
 stall  out  1  freeze pipeline stages upstream of and including MEM
 rdata  out  DATA_W  load result to write-back
 rdata_valid  out  1  rdata valid this cycle
 wb_en  out  1  register-file write enable for the completed memory instruction
 err  out  1  one-cycle abort pulse

Function
REQ-005 SHALL implement FSM states IDLE, REQ, DONE.
REQ-006 IDLE: mem_en=1 at a clock edge SHALL capture addr, wdata, rw, and data_write, then move to REQ; mem_en=0 SHALL stay in IDLE.
REQ-007 stall SHALL be combinational: 1 when (IDLE and mem_en=1) or in REQ; 0 in DONE and in IDLE with mem_en=0.
REQ-008 REQ: mem_req=1, mem_we=~captured rw, mem_addr and mem_wdata from captured registers, all stable until acknowledge.
REQ-009 REQ with mem_ack=1 SHALL move to DONE; on a read, mem_rdata SHALL be registered into rdata at that edge.
REQ-010 DONE lasts exactly one cycle: rdata_valid=captured rw, wb_en=captured data_write, mem_req=0; then unconditionally to IDLE.
REQ-011 mem_en seen in DONE SHALL be ignored, because it belongs to the instruction being completed; one request per instruction.
REQ-012 mem_ack in IDLE or DONE SHALL be ignored with no state change.
REQ-013 Minimum occupancy SHALL be 3 cycles (IDLE accept, REQ with ack in the same cycle, DONE); each extra REQ cycle adds one.
REQ-014 rdata SHALL hold its last value outside DONE; rdata_valid and wb_en SHALL be 0 outside DONE.
REQ-015 mem_we, mem_addr, and mem_wdata SHALL be don't-care while mem_req=0, but driven to registered values, not X.

Reset
REQ-016 rst_n=0 SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, rdata_valid=0, wb_en=0, err=0, and clear the timeout counter.
REQ-017 Reset asserted during REQ SHALL drop mem_req asynchronously; the pending operation is discarded and a late mem_ack after reset is ignored.

Configuration
REQ-018 With macro MEM_TIMEOUT_EN defined, a counter SHALL increment each REQ cycle without mem_ack; on reaching TIMEOUT_CYCLES, the FSM SHALL go to DONE with err=1, wb_en=0, rdata_valid=0, and rdata unchanged.
REQ-019 If mem_ack arrives in the same cycle the limit is reached, the ack SHALL win: normal completion with err=0.
REQ-020 Without MEM_TIMEOUT_EN, REQ SHALL wait indefinitely for mem_ack, err SHALL be tied 0, and no counter logic SHALL be present.

Verification
REQ-021 Load: mem_en=1, rw=1, data_write=1, addr=0x0040; mem_ack after 2 REQ cycles with mem_rdata=0xBEEF -> stall=1 for 3 cycles, then DONE with rdata=0xBEEF, rdata_valid=1, wb_en=1.
REQ-022 Store: rw=0, addr=0x0010, wdata=0x1234, ack in the first REQ cycle -> mem_we=1, mem_addr=0x0010, mem_wdata=0x1234 for one cycle; DONE with rdata_valid=0, wb_en=0.
REQ-023 Back-to-back: mem_en held high through DONE -> exactly one request per instruction; the next request starts only after IDLE accept.
REQ-024 Reset mid-REQ: rst_n low 1 cycle into REQ -> mem_req=0 the same cycle; an ack 2 cycles later produces no DONE.
REQ-025 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> DONE after 4 REQ cycles with err=1 for 1 cycle and wb_en=0; the ack-on-limit-cycle case completes normally with err=0.
REQ-026 Stray mem_ack in IDLE -> no state change, rdata unchanged.
